alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage between decode and writeback. Takes one ALU op (4-bit opcode from the
//  definitions package: kADD..kSLT) plus operands and a dest tag over a valid/ready handshake.
//  Registers the result and presents it downstream on a second valid/ready handshake.
//  LSH/RSH use an iterative 1-bit-per-cycle shifter, so they are multi-cycle.
//  All other ops take one cycle.
// PARAMETERS
//  W      8  operand/result width (bits)
//  TAG_W  3  destination-register tag width, passed through unchanged
// PORTS
//  Clk         in   1      clock, rising edge
//  Reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      upstream op valid
//  in_ready    out  1      stage can accept op this cycle
//  in_op       in   4      opcode (kADD..kSLT)
//  in_a        in   W      operand A
//  in_b        in   W      operand B / shift amount
//  in_tag      in   TAG_W  destination tag
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_result  out  W      result
//  out_tag     out  TAG_W  tag of result
//  out_zero    out  1      out_result == 0
//  out_err     out  1      opcode was undefined (4'b1010..4'b1111)
// BEHAVIOUR
//  Reset (async, Reset_n low): state=IDLE; out_valid, out_result, out_tag, out_zero,
//    out_err = 0; shift counter/work reg = 0. in_ready = 0 while Reset_n low.
//    Reset mid-shift abandons the op; no result is produced.
//  States: IDLE, SHIFT.
//  in_ready = Reset_n && state==IDLE && (!out_valid || out_ready)  (combinational).
//  Accept = in_valid && in_ready, sampled on the rising edge.
//  Output handshake: result transfers when out_valid && out_ready.
//    - out_valid drops on that edge unless a new result is written on the same edge.
//    - result and tag stay stable while out_valid && !out_ready.
//  Single-cycle ops (ADD,SUB,AND,OR,XOR,SEQ,SNE,SLT,undefined):
//    - result written on the accept edge; out_valid=1 the following cycle.
//    - back-to-back accepts give one result per cycle.
//  Arithmetic:
//    - ADD/SUB wrap modulo 2^W; no carry is output.
//    - SEQ/SNE: {W-1 zeros, a==b / a!=b}.
//    - SLT: signed two's-complement a<b, zero-extended to W.
//    - Undefined op: result 0, out_err=1, out_zero=1.
//  Shifts (LSH=a<<n logical, RSH=a>>n logical, zero fill):
//    - n = min(in_b, W), unsigned.
//    - n==0: single-cycle, result=a.
//    - n>=1: on accept, load work=a, cnt=n, go to SHIFT.
//    - In SHIFT each edge: work shifts 1 bit, cnt decrements.
//    - On the edge where cnt==1: write the shifted value to the output regs, go to IDLE.
//    - out_valid rises n edges after the accept edge; n=W yields 0 after W cycles.
//    - in_ready=0 throughout SHIFT. out_valid is guaranteed 0 when SHIFT completes,
//      because accept required the output reg to be free or draining.
//  out_zero and out_err are registered with out_result; out_tag = tag captured at accept.
//  in_op, in_a, in_b and in_tag are ignored when no accept occurs.
// TESTING
//  1. ADD a=8'hF0 b=8'h20, out_ready=1 -> next cycle out_result=8'h10, out_zero=0, tag echoed.
//  2. SLT a=8'hFF b=8'h01 -> 1; SUB a=8'h05 b=8'h05 -> 0, out_zero=1; op=4'hC -> 0, out_err=1.
//  3. LSH a=8'h81 b=3 -> in_ready low 3 cycles, out_valid 3 edges after accept,
//     result 8'h08; RSH b=8'hC8 (clamped to 8) -> 8'h00 after 8 cycles.
//  4. out_ready=0 for 5 cycles after a result -> out_valid/result/tag held, in_ready=0;
//     raise out_ready -> new op accepted on the same edge the result drains.
//  5. Stream 4 single-cycle ops with in_valid=out_ready=1 -> 4 results on 4 consecutive cycles.
//  6. Assert Reset_n=0 mid-LSH (cnt=2) -> immediate out_valid=0, state IDLE;
//     after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: one ALU op per valid/ready handshake, registered result on a second handshake.
// LSH/RSH run on an iterative 1-bit-per-cycle shifter; all other ops complete in one cycle.
module alu_exec_stage #(
    parameter int W     = 8,
    parameter int TAG_W = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [3:0] K_ADD = 4'd0;
    localparam logic [3:0] K_SUB = 4'd1;
    localparam logic [3:0] K_AND = 4'd2;
    localparam logic [3:0] K_OR  = 4'd3;
    localparam logic [3:0] K_XOR = 4'd4;
    localparam logic [3:0] K_LSH = 4'd5;
    localparam logic [3:0] K_RSH = 4'd6;
    localparam logic [3:0] K_SEQ = 4'd7;
    localparam logic [3:0] K_SNE = 4'd8;
    localparam logic [3:0] K_SLT = 4'd9;

    localparam int                CNT_W   = $clog2(W + 1);
    localparam logic [W-1:0]      W_OPND  = W'(W);
    localparam logic [CNT_W-1:0]  W_CNT   = CNT_W'(W);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    // Single-cycle result, returned as {err, result}; shifts only arrive here with a zero amount.
    function automatic logic [W:0] alu_single(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         e;
        r = {W{1'b0}};
        e = 1'b0;
        case (op)
            K_ADD:        r = a + b;
            K_SUB:        r = a - b;
            K_AND:        r = a & b;
            K_OR:         r = a | b;
            K_XOR:        r = a ^ b;
            K_SEQ:        r = {{(W-1){1'b0}}, (a == b)};
            K_SNE:        r = {{(W-1){1'b0}}, (a != b)};
            K_SLT:        r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            K_LSH, K_RSH: r = a;
            default: begin
                r = {W{1'b0}};
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    state_t             state_q, state_d;
    logic [W-1:0]       work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shl_q, shl_d;
    logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_zero_q, out_zero_d;
    logic               out_err_q, out_err_d;

    logic               accept_s;
    logic               is_shift_s;
    logic [CNT_W-1:0]   shamt_s;
    logic [W-1:0]       shifted_s;
    logic [W:0]         single_s;

    // Handshake qualifiers and datapath helpers.
    always_comb begin
        in_ready   = Reset_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready;
        is_shift_s = (in_op == K_LSH) || (in_op == K_RSH);
        shamt_s    = (in_b >= W_OPND) ? W_CNT : in_b[CNT_W-1:0];
        shifted_s  = shl_q ? {work_q[W-2:0], 1'b0} : {1'b0, work_q[W-1:1]};
        single_s   = alu_single(in_op, in_a, in_b);
    end

    // Next-state logic for the control FSM, shifter and output register.
    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        shl_d        = shl_q;
        pend_tag_d   = pend_tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_zero_d   = out_zero_q;
        out_err_d    = out_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_shift_s && (shamt_s != CNT_ZERO)) begin
                    state_d    = ST_SHIFT;
                    work_d     = in_a;
                    cnt_d      = shamt_s;
                    shl_d      = (in_op == K_LSH);
                    pend_tag_d = in_tag;
                end else if (accept_s) begin
                    out_valid_d  = 1'b1;
                    out_result_d = single_s[W-1:0];
                    out_err_d    = single_s[W];
                    out_zero_d   = (single_s[W-1:0] == {W{1'b0}});
                    out_tag_d    = in_tag;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted_s;
                cnt_d  = cnt_q - CNT_ONE;
                // Output register is guaranteed free here: accept required it to be idle or draining.
                if (cnt_q == CNT_ONE) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b1;
                    out_result_d = shifted_s;
                    out_err_d    = 1'b0;
                    out_zero_d   = (shifted_s == {W{1'b0}});
                    out_tag_d    = pend_tag_q;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any shift in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            work_q       <= {W{1'b0}};
            cnt_q        <= CNT_ZERO;
            shl_q        <= 1'b0;
            pend_tag_q   <= {TAG_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_result_q <= {W{1'b0}};
            out_tag_q    <= {TAG_W{1'b0}};
            out_zero_q   <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            shl_q        <= shl_d;
            pend_tag_q   <= pend_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_zero_q   <= out_zero_d;
            out_err_q    <= out_err_d;
        end
    end

    // Output drive.
    always_comb begin
        out_valid  = out_valid_q;
        out_result = out_result_q;
        out_tag    = out_tag_q;
        out_zero   = out_zero_q;
        out_err    = out_err_q;
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model (expected results queued with their due cycle).
module tb_alu_exec_stage;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSH = 4'd5;
    localparam logic [3:0] OP_RSH = 4'd6;
    localparam logic [3:0] OP_SEQ = 4'd7;
    localparam logic [3:0] OP_SNE = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_tag;
    logic       out_zero;
    logic       out_err;

    alu_exec_stage #(.W(8), .TAG_W(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] res;
        logic [2:0] tag;
        logic       err;
        int         rdy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   busy_until = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outcome of one accepted op; rdy is the cycle in which out_valid should be seen.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] tg, input int c);
        exp_t e;
        int ai, bi, sa, sb, r, n;
        ai = int'(a);
        bi = int'(b);
        sa = (ai > 127) ? ai - 256 : ai;
        sb = (bi > 127) ? bi - 256 : bi;
        n  = (bi > 8) ? 8 : bi;
        r  = 0;
        e.err = 1'b0;
        e.rdy = c + 1;
        case (op)
            OP_ADD: r = (ai + bi) % 256;
            OP_SUB: r = (ai - bi + 256) % 256;
            OP_AND: r = ai & bi;
            OP_OR:  r = ai | bi;
            OP_XOR: r = ai ^ bi;
            OP_SEQ: r = (ai == bi) ? 1 : 0;
            OP_SNE: r = (ai != bi) ? 1 : 0;
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_LSH: begin r = (ai << n) % 256; e.rdy = c + 1 + n; end
            OP_RSH: begin r = ai >> n;         e.rdy = c + 1 + n; end
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.res = 8'(r);
        e.tag = tg;
        return e;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, predict, advance.
    task automatic step(input logic iv, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] tg, input logic ordy);
        logic exp_ov, exp_ir;
        exp_t e;
        exp_ov = (q.size() > 0) && (q[0].rdy <= cyc);
        check_val("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check_val("out_result", 32'(out_result), 32'(q[0].res));
            check_val("out_tag",    32'(out_tag),    32'(q[0].tag));
            check_val("out_zero",   32'(out_zero),   32'(q[0].res == 8'h00));
            check_val("out_err",    32'(out_err),    32'(q[0].err));
        end
        in_valid  = iv;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        exp_ir = (cyc >= busy_until) && (!exp_ov || ordy);
        check_val("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ov && ordy) begin
            void'(q.pop_front());
        end
        if (iv && exp_ir) begin
            e = model(op, a, b, tg, cyc);
            q.push_back(e);
            busy_until = e.rdy;
        end
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 8'h00, 8'h00, 3'd0, ordy);
    endtask

    initial begin
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_tag    = 3'd0;
        out_ready = 1'b0;
        #12;
        check_val("rst_out_valid", 32'(out_valid),  32'd0);
        check_val("rst_in_ready",  32'(in_ready),   32'd0);
        check_val("rst_result",    32'(out_result), 32'd0);
        check_val("rst_tag",       32'(out_tag),    32'd0);
        check_val("rst_zero",      32'(out_zero),   32'd0);
        check_val("rst_err",       32'(out_err),    32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle(1'b1);

        // ADD with wrap, tag echoed.
        step(1'b1, OP_ADD, 8'hF0, 8'h20, 3'd5, 1'b1);
        check_val("t1_valid", 32'(out_valid), 32'd1);
        check_val("t1_res",   32'(out_result), 32'h10);
        check_val("t1_zero",  32'(out_zero), 32'd0);
        check_val("t1_tag",   32'(out_tag), 32'd5);

        // Signed compare, zero flag, undefined opcode.
        step(1'b1, OP_SLT, 8'hFF, 8'h01, 3'd1, 1'b1);
        check_val("t2_slt", 32'(out_result), 32'd1);
        step(1'b1, OP_SUB, 8'h05, 8'h05, 3'd2, 1'b1);
        check_val("t2_sub",  32'(out_result), 32'd0);
        check_val("t2_zero", 32'(out_zero), 32'd1);
        step(1'b1, 4'hC, 8'h12, 8'h34, 3'd3, 1'b1);
        check_val("t2_undef_res",  32'(out_result), 32'd0);
        check_val("t2_undef_err",  32'(out_err), 32'd1);
        check_val("t2_undef_zero", 32'(out_zero), 32'd1);
        idle(1'b1);

        // Multi-cycle shifts, including a clamped amount; in_valid held high while busy.
        step(1'b1, OP_LSH, 8'h81, 8'd3, 3'd4, 1'b1);
        check_val("t3_busy", 32'(in_ready), 32'd0);
        repeat (3) step(1'b1, OP_ADD, 8'h01, 8'h01, 3'd7, 1'b0);
        check_val("t3_lsh_valid", 32'(out_valid), 32'd1);
        check_val("t3_lsh_res",   32'(out_result), 32'h08);
        idle(1'b1);
        step(1'b1, OP_RSH, 8'hFF, 8'hC8, 3'd6, 1'b1);
        repeat (7) idle(1'b1);
        check_val("t3_rsh_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        check_val("t3_rsh_valid", 32'(out_valid), 32'd1);
        check_val("t3_rsh_res",   32'(out_result), 32'h00);
        idle(1'b1);

        // Backpressure hold, then drain and accept on the same edge.
        step(1'b1, OP_XOR, 8'hA5, 8'h0F, 3'd2, 1'b0);
        repeat (5) step(1'b1, OP_AND, 8'hFF, 8'h3C, 3'd1, 1'b0);
        check_val("t4_held_res", 32'(out_result), 32'hAA);
        check_val("t4_blocked",  32'(in_ready), 32'd0);
        step(1'b1, OP_OR, 8'h30, 8'h03, 3'd3, 1'b1);
        check_val("t4_new_res", 32'(out_result), 32'h33);
        check_val("t4_new_tag", 32'(out_tag), 32'd3);

        // Back-to-back stream: one result per cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, OP_ADD, 8'(i), 8'h10, 3'(i), 1'b1);
            check_val("t5_stream_valid", 32'(out_valid), 32'd1);
        end
        idle(1'b1);

        // Reset in the middle of a shift abandons the op.
        step(1'b1, OP_LSH, 8'h81, 8'd3, 3'd5, 1'b1);
        idle(1'b1);
        Reset_n = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(out_valid), 32'd0);
        check_val("t6_rst_ready", 32'(in_ready), 32'd0);
        q.delete();
        busy_until = 0;
        @(posedge Clk);
        cyc++;
        #1;
        Reset_n = 1'b1;
        #1;
        out_ready = 1'b1;
        #1;
        check_val("t6_ready_after", 32'(in_ready), 32'd1);
        repeat (5) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
            step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 rb, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 40; i++) begin
            if (q.size() > 0) begin
                idle(1'b1);
            end
        end
        check_val("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
